i2s_tx: RTL and testbench

- Serializes stereo audio from the EQ filter bank onto an I2S link to the codec DAC.
- Clock master: generates bclk and lrclk from clk by integer division, and shifts out sdata in standard (Philips) I2S format.
- Upstream filter output enters through a one-deep valid/ready holding register, so filter timing is decoupled from frame timing.
- Missed samples are detected and flagged as underruns.

---
 rtl/i2s_tx.sv | 132 +++++++++++++
 tb/tb_i2s_tx.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx.sv
// i2s_tx: I2S clock-master transmitter (Philips format, MSB first).
//   Divides clk into bclk/lrclk, serializes one stereo frame per
//   2*SLOT_W bclk periods, and takes samples through a one-deep
//   valid/ready holding register that is drained at each frame load.
//
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   left_in, right_in stereo sample (two's complement, DATA_W bits)
//   sample_valid      sample present this cycle
//   sample_ready      holding register empty; accept on valid & ready
//   bclk, lrclk       I2S bit clock and word select (0 = left)
//   sdata             serial data, updated on bclk falling edges
//   frame_start       one-clk pulse at each frame load
//   underrun          one-clk pulse when a frame load finds no sample
//
// Optional build macro:
//   I2S_TX_MUTE_ON_UNDERRUN_EN  underrun frame loads zeros instead of
//                               repeating the previous frame.
module i2s_tx #(
  parameter int DATA_W   = 16,
  parameter int SLOT_W   = 32,
  parameter int BCLK_DIV = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] left_in,
  input  logic [DATA_W-1:0] right_in,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              bclk,
  output logic              lrclk,
  output logic              sdata,
  output logic              frame_start,
  output logic              underrun
);

  localparam int PW = $clog2(2*SLOT_W);
  localparam int CW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(2*SLOT_W - 1);

  typedef struct packed {
    logic [DATA_W-1:0] l;
    logic [DATA_W-1:0] r;
  } stereo_t;

  logic [CW-1:0]     cnt;
  logic [PW-1:0]     p, p_nxt;
  logic              hold_full;
  stereo_t           hold, frame;
  logic              tc, fall, load, accept, bit_nxt;
  logic [DATA_W-1:0] l_sh, r_sh;

  assign tc           = (cnt == CW'(BCLK_DIV - 1));
  assign fall         = tc & bclk;
  assign load         = fall & (p == P_LAST);
  assign accept       = sample_valid & ~hold_full;
  assign sample_ready = ~hold_full;
  assign p_nxt        = (p == P_LAST) ? '0 : p + 1'b1;

  // Bit for the period being entered. One-bclk I2S delay: MSB sits at
  // p=1 of the left slot and p=SLOT_W+1 of the right slot. Selecting by
  // left-shift keeps the index arithmetic free of width games.
  always_comb begin
    bit_nxt = 1'b0;
    l_sh    = '0;
    r_sh    = '0;
    if (int'(p_nxt) >= 1 && int'(p_nxt) <= DATA_W) begin
      l_sh    = frame.l << (int'(p_nxt) - 1);
      bit_nxt = l_sh[DATA_W-1];
    end else if (int'(p_nxt) >= SLOT_W + 1 && int'(p_nxt) <= SLOT_W + DATA_W) begin
      r_sh    = frame.r << (int'(p_nxt) - SLOT_W - 1);
      bit_nxt = r_sh[DATA_W-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      bclk        <= 1'b0;
      p           <= P_LAST;
      lrclk       <= 1'b0;
      sdata       <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      hold_full   <= 1'b0;
      hold        <= '0;
      frame       <= '0;
    end else begin
      frame_start <= 1'b0;
      underrun    <= 1'b0;

      if (tc) begin
        cnt  <= '0;
        bclk <= ~bclk;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (fall) begin
        p     <= p_nxt;
        lrclk <= (int'(p_nxt) >= SLOT_W);
        sdata <= bit_nxt;
      end

      // p wraps to 0 on the load, whose bit is always 0, so the new
      // frame is first used one bclk later (p=1).
      if (load) begin
        frame_start <= 1'b1;
        if (hold_full) begin
          frame <= hold;
        end else begin
          underrun <= 1'b1;
`ifdef I2S_TX_MUTE_ON_UNDERRUN_EN
          frame <= '0;
`endif
        end
      end

      // Load with a full holding register drains it; an accept in that
      // cycle is impossible since ready was low. An accept coinciding
      // with an empty-load is held for the following frame (no bypass).
      if (load && hold_full) begin
        hold_full <= 1'b0;
      end else if (accept) begin
        hold_full <= 1'b1;
        hold.l    <= left_in;
        hold.r    <= right_in;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
module tb_i2s_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] left_in = '0, right_in = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready, bclk, lrclk, sdata, frame_start, underrun;

  int checks = 0;
  int failures = 0;
  logic fb [64];
  logic flr[64];

  i2s_tx #(.DATA_W(16), .SLOT_W(32), .BCLK_DIV(2)) dut (
    .clk(clk), .reset(reset), .left_in(left_in), .right_in(right_in),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
    .frame_start(frame_start), .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Advance to the sample point right after the next frame_start edge.
  task automatic wait_frame(input string tag, output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (!frame_start && n < 600);
    chk({tag, "_frame_start"}, 32'(frame_start), 32'd1);
  endtask

  // Sample sdata/lrclk once per bclk period for p=0..63; ends inside p=63.
  task automatic capture();
    for (int p = 0; p < 64; p++) begin
      fb[p]  = sdata;
      flr[p] = lrclk;
      if (p < 63) step(4);
    end
  endtask

  task automatic check_frame(input string tag, input logic [15:0] l, input logic [15:0] r);
    logic [15:0] lw, rw;
    logic        pad, lr_ok;
    lw = '0; rw = '0; pad = 1'b0; lr_ok = 1'b1;
    for (int p = 0; p < 64; p++) begin
      if (p >= 1 && p <= 16)       lw = {lw[14:0], fb[p]};
      else if (p >= 33 && p <= 48) rw = {rw[14:0], fb[p]};
      else                         pad = pad | fb[p];
      if (flr[p] !== (p >= 32)) lr_ok = 1'b0;
    end
    chk({tag, "_left"},  32'(lw), 32'(l));
    chk({tag, "_right"}, 32'(rw), 32'(r));
    chk({tag, "_pad"},   32'(pad), 32'd0);
    chk({tag, "_lrclk"}, 32'(lr_ok), 32'd1);
  endtask

  initial begin
    int n;
    logic [7:0] bv;
    logic [15:0] rep_l, rep_r, mute_l, mute_r;

    // Reset values
    #2;
    chk("rst_bclk", 32'(bclk), 0);
    chk("rst_lrclk", 32'(lrclk), 0);
    chk("rst_sdata", 32'(sdata), 0);
    chk("rst_frame_start", 32'(frame_start), 0);
    chk("rst_underrun", 32'(underrun), 0);
    chk("rst_ready", 32'(sample_ready), 1);
    step(2);
    reset = 1'b0;

    // First load at the first bclk fall: 4 clk after release
    n = 0;
    do begin step(1); n++; end while (!frame_start && n < 20);
    chk("first_load_latency", 32'(n), 32'd4);
    chk("first_underrun", 32'(underrun), 1);
    bv = '0;
    for (int i = 0; i < 8; i++) begin
      bv = {bv[6:0], bclk};
      step(1);
    end
    chk("bclk_pattern", 32'(bv), 32'h33);
    wait_frame("f2", n);
    chk("frame_period", 32'(n), 32'd248);
    chk("f2_underrun", 32'(underrun), 1);
    capture();
    check_frame("silent", 16'h0000, 16'h0000);
    wait_frame("f3", n);
    chk("f3_underrun", 32'(underrun), 1);

    // Single sample ahead of a load
    sample_valid = 1'b1; left_in = 16'hA5C3; right_in = 16'h0001;
    step(1);
    chk("t2_ready_low", 32'(sample_ready), 0);
    sample_valid = 1'b0;
    wait_frame("f4", n);
    chk("t2_no_underrun", 32'(underrun), 0);
    chk("t2_ready_back", 32'(sample_ready), 1);
    capture();
    check_frame("a5c3", 16'hA5C3, 16'h0001);
    wait_frame("f5", n);
    chk("f5_underrun", 32'(underrun), 1);

    // Back-to-back S1, S2
    sample_valid = 1'b1; left_in = 16'h1234; right_in = 16'h5678;
    step(1);
    chk("s1_accepted", 32'(sample_ready), 0);
    left_in = 16'h9ABC; right_in = 16'hDEF0;
    step(100);
    chk("s2_held_off", 32'(sample_ready), 0);
    wait_frame("f6", n);
    chk("s1_load_no_underrun", 32'(underrun), 0);
    chk("s1_load_ready", 32'(sample_ready), 1);
    step(1);
    chk("s2_accepted", 32'(sample_ready), 0);
    sample_valid = 1'b0;
    capture();
    check_frame("s1", 16'h1234, 16'h5678);
    wait_frame("f7", n);
    chk("s2_load_no_underrun", 32'(underrun), 0);
    capture();
    check_frame("s2", 16'h9ABC, 16'hDEF0);
    wait_frame("f8", n);
    chk("f8_underrun", 32'(underrun), 1);

`ifdef I2S_TX_MUTE_ON_UNDERRUN_EN
    rep_l = 16'h0000; rep_r = 16'h0000; mute_l = 16'h0000; mute_r = 16'h0000;
`else
    rep_l = 16'h9ABC; rep_r = 16'hDEF0; mute_l = 16'h7FFF; mute_r = 16'h8000;
`endif

    // Accept in the very cycle of an empty-holding frame load
    step(255);
    chk("pre_load_quiet", 32'(frame_start), 0);
    sample_valid = 1'b1; left_in = 16'h7FFF; right_in = 16'h8000;
    step(1);
    sample_valid = 1'b0;
    chk("coload_frame_start", 32'(frame_start), 1);
    chk("coload_underrun", 32'(underrun), 1);
    chk("coload_accepted", 32'(sample_ready), 0);
    capture();
    check_frame("coload_repeat", rep_l, rep_r);
    wait_frame("f10", n);
    chk("f10_no_underrun", 32'(underrun), 0);
    capture();
    check_frame("max", 16'h7FFF, 16'h8000);
    wait_frame("f11", n);
    chk("f11_underrun", 32'(underrun), 1);
    capture();
    check_frame("underrun_frame", mute_l, mute_r);
    wait_frame("f12", n);

    // Reset mid-frame at p=40
    sample_valid = 1'b1; left_in = 16'h1111; right_in = 16'h2222;
    step(1);
    sample_valid = 1'b0;
    step(161);
    chk("p40_bclk", 32'(bclk), 1);
    chk("p40_lrclk", 32'(lrclk), 1);
    chk("p40_ready", 32'(sample_ready), 0);
    reset = 1'b1;
    #1;
    chk("async_bclk", 32'(bclk), 0);
    chk("async_lrclk", 32'(lrclk), 0);
    chk("async_sdata", 32'(sdata), 0);
    chk("async_ready", 32'(sample_ready), 1);
    step(2);
    reset = 1'b0;
    n = 0;
    do begin step(1); n++; end while (!frame_start && n < 20);
    chk("rerst_load_latency", 32'(n), 32'd4);
    chk("rerst_lrclk", 32'(lrclk), 0);
    chk("rerst_underrun", 32'(underrun), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
